// File: rtl/islemci_core.sv
// RV32I core: single-cycle execute with a one-word fetch lag from a registered
// instruction memory. Owns the register file and a word-organised data memory.
module islemci_core #(
  parameter int VERI_DERINLIK = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ps,
  input  logic [31:0] buyruk
);
  localparam int IDX_W = (VERI_DERINLIK > 1) ? $clog2(VERI_DERINLIK) : 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [31:0] r_ps;
  logic        r_gecerli;
  logic [31:0] yazmac_obegi [0:31];
  logic [31:0] veri_bellek  [0:VERI_DERINLIK-1];

  logic [6:0]       w_opcode;
  logic [4:0]       w_rd, w_rs1, w_rs2;
  logic [2:0]       w_f3;
  logic [31:0]      w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0]      w_pc, w_rs1_val, w_rs2_val, w_addr, w_word;
  logic [IDX_W-1:0] w_idx;
  logic [7:0]       w_lane8;
  logic [15:0]      w_lane16;
  logic             w_we, w_taken, w_st, w_cond;
  logic [31:0]      w_wd, w_target, w_st_word;

  assign ps        = r_ps;
  assign w_opcode  = buyruk[6:0];
  assign w_rd      = buyruk[11:7];
  assign w_f3      = buyruk[14:12];
  assign w_rs1     = buyruk[19:15];
  assign w_rs2     = buyruk[24:20];
  assign w_imm_i   = {{20{buyruk[31]}}, buyruk[31:20]};
  assign w_imm_s   = {{20{buyruk[31]}}, buyruk[31:25], buyruk[11:7]};
  assign w_imm_b   = {{19{buyruk[31]}}, buyruk[31], buyruk[7], buyruk[30:25], buyruk[11:8], 1'b0};
  assign w_imm_u   = {buyruk[31:12], 12'b0};
  assign w_imm_j   = {{11{buyruk[31]}}, buyruk[31], buyruk[19:12], buyruk[20], buyruk[30:21], 1'b0};
  // The word on buyruk was fetched from the previous ps.
  assign w_pc      = r_ps - 32'd4;
  assign w_rs1_val = yazmac_obegi[w_rs1];
  assign w_rs2_val = yazmac_obegi[w_rs2];
  assign w_addr    = w_rs1_val + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
  assign w_idx     = IDX_W'(w_addr >> 2);
  assign w_word    = veri_bellek[w_idx];
  assign w_lane8   = 8'(w_word >> {w_addr[1:0], 3'b000});
  assign w_lane16  = w_addr[1] ? w_word[31:16] : w_word[15:0];

  function automatic logic [31:0] f_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] f3, input logic alt);
    logic [31:0] y;
    case (f3)
      3'd0:    y = alt ? (a - b) : (a + b);
      3'd1:    y = a << b[4:0];
      3'd2:    y = {31'b0, $signed(a) < $signed(b)};
      3'd3:    y = {31'b0, a < b};
      3'd4:    y = a ^ b;
      3'd5:    y = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    y = a | b;
      default: y = a & b;
    endcase
    return y;
  endfunction

  always_comb begin
    w_we      = 1'b0;
    w_wd      = '0;
    w_taken   = 1'b0;
    w_target  = '0;
    w_st      = 1'b0;
    w_st_word = w_word;
    w_cond    = 1'b0;
    if (r_gecerli) begin
      case (w_opcode)
        OPC_LUI:   begin w_we = 1'b1; w_wd = w_imm_u; end
        OPC_AUIPC: begin w_we = 1'b1; w_wd = w_pc + w_imm_u; end
        OPC_JAL: begin
          w_we = 1'b1; w_wd = r_ps; w_taken = 1'b1; w_target = w_pc + w_imm_j;
        end
        OPC_JALR: begin
          w_we = 1'b1; w_wd = r_ps; w_taken = 1'b1;
          w_target = (w_rs1_val + w_imm_i) & ~32'd1;
        end
        OPC_BRANCH: begin
          case (w_f3)
            3'b000:  w_cond = (w_rs1_val == w_rs2_val);
            3'b001:  w_cond = (w_rs1_val != w_rs2_val);
            3'b100:  w_cond = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101:  w_cond = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110:  w_cond = (w_rs1_val <  w_rs2_val);
            3'b111:  w_cond = (w_rs1_val >= w_rs2_val);
            default: w_cond = 1'b0;
          endcase
          w_taken  = w_cond;
          w_target = w_pc + w_imm_b;
        end
        OPC_LOAD: begin
          w_we = 1'b1;
          case (w_f3)
            3'b000:  w_wd = {{24{w_lane8[7]}}, w_lane8};
            3'b001:  w_wd = {{16{w_lane16[15]}}, w_lane16};
            3'b010:  w_wd = w_word;
            3'b100:  w_wd = {24'b0, w_lane8};
            3'b101:  w_wd = {16'b0, w_lane16};
            default: w_we = 1'b0;
          endcase
        end
        OPC_STORE: begin
          w_st = 1'b1;
          case (w_f3)
            3'b000:  w_st_word[{w_addr[1:0], 3'b000} +: 8] = w_rs2_val[7:0];
            3'b001:  w_st_word[{w_addr[1], 4'b0000} +: 16] = w_rs2_val[15:0];
            3'b010:  w_st_word = w_rs2_val;
            default: w_st = 1'b0;
          endcase
        end
        OPC_OPIMM: begin
          w_we = 1'b1;
          w_wd = f_alu(w_rs1_val, w_imm_i, w_f3, (w_f3 == 3'd5) && buyruk[30]);
        end
        OPC_OP: begin
          w_we = 1'b1;
          w_wd = f_alu(w_rs1_val, w_rs2_val, w_f3, buyruk[30]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ps      <= '0;
      r_gecerli <= 1'b0;
      for (int i = 0; i < 32; i++) yazmac_obegi[i] <= '0;
    end else begin
      // A taken transfer squashes the word fetched on this same edge.
      if (w_taken) begin
        r_ps      <= w_target;
        r_gecerli <= 1'b0;
      end else begin
        r_ps      <= r_ps + 32'd4;
        r_gecerli <= 1'b1;
      end
      if (w_we && (w_rd != 5'd0)) yazmac_obegi[w_rd] <= w_wd;
    end
  end

  // Data memory has no reset; a store in flight when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_st) veri_bellek[w_idx] <= w_st_word;
  end
endmodule

// File: tb/tb_islemci_core.sv
// Bench for islemci_core: directed programs plus random RV32I programs checked
// cycle by cycle against an instruction-level reference model.
module tb_islemci_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ps;
  logic [31:0] buyruk = 32'h0000_0013;

  islemci_core #(.VERI_DERINLIK(256)) dut (
    .clk(clk), .rst(rst), .ps(ps), .buyruk(buyruk)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [0:63];
  always @(posedge clk) buyruk <= imem[ps[7:2]];

  // Reference architectural state
  logic [31:0] m_x   [0:31];
  logic [31:0] m_mem [0:255];
  logic [31:0] m_pc;
  bit          m_bub;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] opc);
    logic [11:0] im;
    im = imm[11:0];
    return {im, 5'(rs1), 3'(f3), 5'(rd), opc};
  endfunction

  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
    logic [11:0] im;
    im = imm[11:0];
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    logic [12:0] im;
    im = imm[12:0];
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(int imm, int rd);
    logic [20:0] im;
    im = imm[20:0];
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] rand_instr();
    int k, f3, sel;
    int branch_f3 [6] = '{0, 1, 4, 5, 6, 7};
    int load_f3   [5] = '{0, 1, 2, 4, 5};
    k = int'($urandom_range(0, 11));
    case (k)
      0: return {20'($urandom()), 5'($urandom_range(0, 7)), 7'b0110111};
      1: return {20'($urandom()), 5'($urandom_range(0, 7)), 7'b0010111};
      2: return enc_j(int'($urandom_range(1, 8)) * 4, int'($urandom_range(0, 7)));
      3: return enc_i(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), 0,
                      int'($urandom_range(0, 7)), 7'b1100111);
      4: begin
        sel = int'($urandom_range(0, 5));
        return enc_b(int'($urandom_range(1, 6)) * 4, int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 7)), branch_f3[sel]);
      end
      5: begin
        sel = int'($urandom_range(0, 4));
        return enc_i(int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)), load_f3[sel],
                     int'($urandom_range(0, 7)), 7'b0000011);
      end
      6: return enc_s(int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      7, 8: begin
        f3 = int'($urandom_range(0, 7));
        if (f3 == 1) sel = int'($urandom_range(0, 31));
        else if (f3 == 5) sel = int'($urandom_range(0, 31)) + (($urandom_range(0, 1) == 1) ? 1024 : 0);
        else sel = int'($urandom_range(0, 4095));
        return enc_i(sel, int'($urandom_range(0, 7)), f3, int'($urandom_range(0, 7)), 7'b0010011);
      end
      9, 10: begin
        f3 = int'($urandom_range(0, 7));
        sel = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 32 : 0;
        return enc_r(sel, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), f3,
                     int'($urandom_range(0, 7)));
      end
      default: return $urandom();
    endcase
  endfunction

  task automatic m_wr(input int rd, input logic [31:0] v);
    if (rd != 0) m_x[rd] = v;
  endtask

  function automatic logic [31:0] m_alu(int f3, logic [31:0] a, logic [31:0] b, bit alt);
    int sh;
    sh = int'(b & 32'd31);
    case (f3)
      0: return alt ? a - b : a + b;
      1: return a << sh;
      2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3: return (a < b) ? 32'd1 : 32'd0;
      4: return a ^ b;
      5: return alt ? 32'($signed(a) >>> sh) : a >> sh;
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Executes one instruction at m_pc on the model; reports any control transfer.
  task automatic m_exec(output bit taken);
    logic [31:0] ins, a, b, ii, is, ib, ij, nx, addr, w, t, mask;
    logic [7:0]  v8;
    logic [15:0] v16;
    int rd, f3, idx, sh8, sh16;
    ins = imem[m_pc[7:2]];
    rd = int'(ins[11:7]);
    f3 = int'(ins[14:12]);
    a = m_x[ins[19:15]];
    b = m_x[ins[24:20]];
    ii = 32'($signed(ins) >>> 20);
    is = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
    ib = (32'($signed(ins) >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    ij = (32'($signed(ins) >>> 31) << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    nx = m_pc + 32'd4;
    taken = 1'b0;
    case (ins[6:0])
      7'h37: m_wr(rd, ins & 32'hFFFF_F000);
      7'h17: m_wr(rd, m_pc + (ins & 32'hFFFF_F000));
      7'h6F: begin m_wr(rd, m_pc + 32'd4); nx = m_pc + ij; taken = 1'b1; end
      7'h67: begin t = (a + ii) & ~32'd1; m_wr(rd, m_pc + 32'd4); nx = t; taken = 1'b1; end
      7'h63: begin
        case (f3)
          0: taken = (a == b);
          1: taken = (a != b);
          4: taken = ($signed(a) < $signed(b));
          5: taken = ($signed(a) >= $signed(b));
          6: taken = (a < b);
          7: taken = (a >= b);
          default: taken = 1'b0;
        endcase
        if (taken) nx = m_pc + ib;
      end
      7'h03: begin
        addr = a + ii;
        w = m_mem[(addr >> 2) & 32'd255];
        sh8 = 8 * int'(addr[1:0]);
        sh16 = 16 * int'(addr[1]);
        v8 = 8'(w >> sh8);
        v16 = 16'(w >> sh16);
        case (f3)
          0: m_wr(rd, {{24{v8[7]}}, v8});
          1: m_wr(rd, {{16{v16[15]}}, v16});
          2: m_wr(rd, w);
          4: m_wr(rd, {24'b0, v8});
          5: m_wr(rd, {16'b0, v16});
          default: ;
        endcase
      end
      7'h23: begin
        addr = a + is;
        idx = int'((addr >> 2) & 32'd255);
        w = m_mem[idx];
        sh8 = 8 * int'(addr[1:0]);
        sh16 = 16 * int'(addr[1]);
        case (f3)
          0: begin mask = 32'hFF << sh8;   m_mem[idx] = (w & ~mask) | ((b & 32'hFF) << sh8); end
          1: begin mask = 32'hFFFF << sh16; m_mem[idx] = (w & ~mask) | ((b & 32'hFFFF) << sh16); end
          2: m_mem[idx] = b;
          default: ;
        endcase
      end
      7'h13: m_wr(rd, m_alu(f3, a, ii, (f3 == 5) && ins[30]));
      7'h33: m_wr(rd, m_alu(f3, a, b, ins[30]));
      default: ;
    endcase
    m_pc = nx;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_x[i] = '0;
    m_pc = '0;
    m_bub = 1'b1;
  endtask

  task automatic m_edge();
    bit t;
    if (m_bub) m_bub = 1'b0;
    else begin
      m_exec(t);
      if (t) m_bub = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_ps"}, ps, rst ? 32'd0 : (m_bub ? m_pc : m_pc + 32'd4));
    for (int i = 0; i < 32; i++) chk($sformatf("%s_x%0d", tag, i), dut.yazmac_obegi[i], m_x[i]);
  endtask

  task automatic cycles(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      m_edge();
      @(negedge clk);
      check_state(tag);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    repeat (n) begin
      @(negedge clk);
      chk("rst_ps", ps, 32'd0);
    end
    check_state("rst");
    rst = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0013;
  endtask

  task automatic load_prog1();
    clear_imem();
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0070_0113;
    imem[2] = 32'h0020_81b3;
    imem[3] = 32'h0011_a023;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dut.veri_bellek[i] = '0;
      m_mem[i] = '0;
    end
    m_reset();
    clear_imem();

    // Reset held for 10 cycles, then the bubble edge
    load_prog1();
    do_reset(10);
    cycles(1, "bubble");
    chk("bubble_ps", ps, 32'd4);
    cycles(4, "prog1");
    chk("prog1_x1", dut.yazmac_obegi[1], 32'd5);
    chk("prog1_x2", dut.yazmac_obegi[2], 32'd7);
    chk("prog1_x3", dut.yazmac_obegi[3], 32'd12);
    chk("prog1_mem3", dut.veri_bellek[3], 32'd5);
    chk("prog1_ps", ps, 32'd20);

    // x0 stays zero
    clear_imem();
    imem[0] = 32'h0090_0013;
    imem[1] = 32'h0000_0233;
    do_reset(2);
    cycles(3, "x0");
    chk("x0_x0", dut.yazmac_obegi[0], 32'd0);
    chk("x0_x4", dut.yazmac_obegi[4], 32'd0);

    // Byte store and signed/unsigned byte loads
    clear_imem();
    imem[0] = enc_i(-1, 0, 0, 1, 7'b0010011);
    imem[1] = enc_s(1, 1, 0, 0);
    imem[2] = enc_i(1, 0, 0, 5, 7'b0000011);
    imem[3] = enc_i(1, 0, 4, 6, 7'b0000011);
    do_reset(2);
    cycles(5, "byte");
    chk("byte_mem0", dut.veri_bellek[0], 32'h0000_FF00);
    chk("byte_x5", dut.yazmac_obegi[5], 32'hFFFF_FFFF);
    chk("byte_x6", dut.yazmac_obegi[6], 32'h0000_00FF);

    // Taken branch squashes the next word
    clear_imem();
    imem[0] = enc_b(8, 0, 0, 0);
    imem[1] = enc_i(1, 0, 0, 7, 7'b0010011);
    imem[2] = enc_i(2, 0, 0, 8, 7'b0010011);
    do_reset(2);
    exp_q.push_back(32'd4);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd12);
    while (exp_q.size() > 0) begin
      cycles(1, "beq");
      chk("beq_ps_seq", ps, exp_q.pop_front());
    end
    cycles(1, "beq");
    chk("beq_x7", dut.yazmac_obegi[7], 32'd0);
    chk("beq_x8", dut.yazmac_obegi[8], 32'd2);

    // JAL link value
    clear_imem();
    imem[0] = enc_j(16, 1);
    do_reset(2);
    cycles(2, "jal");
    chk("jal_x1", dut.yazmac_obegi[1], 32'd4);
    chk("jal_ps", ps, 32'd16);

    // Reset in the middle of a program
    load_prog1();
    do_reset(2);
    cycles(3, "mid");
    #2 rst = 1'b1;
    m_reset();
    #1;
    check_state("midrst");
    chk("midrst_ps", ps, 32'd0);
    chk("midrst_x1", dut.yazmac_obegi[1], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycles(5, "rerun");
    chk("rerun_x3", dut.yazmac_obegi[3], 32'd12);
    chk("rerun_ps", ps, 32'd20);

    // Random programs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) imem[i] = rand_instr();
      do_reset(2);
      cycles(150, $sformatf("rnd%0d", r));
      for (int i = 0; i < 256; i++) chk($sformatf("rnd%0d_mem%0d", r, i), dut.veri_bellek[i], m_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
